draw_score: RTL and testbench

DRAW_SCORE -- requirements
Module: draw_score

---
 rtl/draw_score_if.sv | 31 +++
 rtl/draw_score.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_draw_score.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_score_if.sv
// vga_if: VGA timing bundle passed between drawing stages.
//   hcount, vcount : current pixel column / row (11 bits each)
//   hblnk, vblnk   : horizontal / vertical blanking flags
//   hsync, vsync   : sync pulses
// Modports: in (consumer side), out (producer side).
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;

    modport in (
        input hcount,
        input vcount,
        input hblnk,
        input vblnk,
        input hsync,
        input vsync
    );

    modport out (
        output hcount,
        output vcount,
        output hblnk,
        output vblnk,
        output hsync,
        output vsync
    );
endinterface

// File: rtl/draw_score.sv
// draw_score: overlays the text "DDD:EEE" (two 3-digit decimal scores separated by ':')
// on a VGA pixel stream. Scores are sampled at the start of each vertical blanking
// interval, converted to BCD by a sequential double-dabble FSM and committed to the
// displayed digit registers 17 cycles later. Pixel path latency is exactly 2 cycles.
//
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset
//   score1   : player-1 score (unsigned, 8 bits)
//   score2   : player-2 score (unsigned, 8 bits)
//   vga_in   : timing from the previous stage (vga_if.in)
//   rgb_i    : pixel colour from the previous stage
//   vga_out  : timing delayed by 2 cycles (vga_if.out)
//   rgb_o    : pixel colour with the score overlay applied
//
// Build option: define DRAW_SCORE_ZERO_BLANK_EN to blank leading-zero digits
// (the units digit is always drawn).
module draw_score #(
    parameter int unsigned   X0        = 16,
    parameter int unsigned   Y0        = 8,
    parameter logic [11:0]   P1_COLOR  = 12'h0F0,
    parameter logic [11:0]   P2_COLOR  = 12'h00F,
    parameter logic [11:0]   SEP_COLOR = 12'hFFF,
    localparam int unsigned  RGB_B     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       score1,
    input  logic [7:0]       score2,
    vga_if.in                vga_in,
    input  logic [RGB_B-1:0] rgb_i,
    vga_if.out               vga_out,
    output logic [RGB_B-1:0] rgb_o
);

    localparam logic [11:0] X0_L = 12'(X0);
    localparam logic [11:0] Y0_L = 12'(Y0);

    // ------------------------------------------------------------------
    // Font ROM: 11 glyphs (0-9, ':'), 16 rows of 8 bits, row 0 in the MSB
    // byte, bit 7 is the leftmost pixel.
    // ------------------------------------------------------------------
    function automatic logic [127:0] glyph_bits(input logic [3:0] code);
        logic [127:0] g;
        case (code)
            4'd0:    g = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            4'd1:    g = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            4'd2:    g = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            4'd3:    g = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            4'd4:    g = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            4'd5:    g = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            4'd6:    g = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            4'd7:    g = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            4'd8:    g = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            4'd9:    g = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            4'd10:   g = 128'h0000_0018_1818_0000_1818_1800_0000_0000;
            default: g = '0;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // BCD converter FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StConv1, StConv2, StCommit} state_e;

    state_e      state_q, state_d;
    logic        in_conv1, in_conv2, in_commit;
    logic        vblnk_prev_q;
    logic        vblank_rise;
    logic [2:0]  cnt_q;
    logic [7:0]  score1_q, score2_q;
    logic [19:0] dd_q;
    logic [19:0] dd_src, dd_adj, dd_next;
    logic [11:0] bcd1_q, bcd2_q;
    logic [11:0] disp1_q, disp2_q;

    assign vblank_rise = vga_in.vblnk & ~vblnk_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A new blanking edge always (re)starts the conversion from score1.
    always_comb begin
        state_d = state_q;
        if (vblank_rise) begin
            state_d = StConv1;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StIdle;
                StConv1:  if (cnt_q == 3'd7) state_d = StConv2;
                StConv2:  if (cnt_q == 3'd7) state_d = StCommit;
                StCommit: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_conv1  = 1'b0;
        in_conv2  = 1'b0;
        in_commit = 1'b0;
        unique case (state_q)
            StIdle:   ;
            StConv1:  in_conv1  = 1'b1;
            StConv2:  in_conv2  = 1'b1;
            StCommit: in_commit = 1'b1;
        endcase
    end

    // One double-dabble step; the first step of each conversion takes its
    // operand straight from the latched score.
    always_comb begin
        dd_src = dd_q;
        if (cnt_q == 3'd0) begin
            dd_src = {12'd0, (in_conv1 ? score1_q : score2_q)};
        end
        dd_adj = dd_src;
        for (int i = 0; i < 3; i++) begin
            if (dd_src[8 + 4*i +: 4] >= 4'd5) begin
                dd_adj[8 + 4*i +: 4] = dd_src[8 + 4*i +: 4] + 4'd3;
            end
        end
        dd_next = {dd_adj[18:0], 1'b0};
    end

    // Resetting vblnk_prev_q high keeps a blanking interval already in
    // progress at reset release from counting as a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev_q <= 1'b1;
            cnt_q        <= '0;
            score1_q     <= '0;
            score2_q     <= '0;
            dd_q         <= '0;
            bcd1_q       <= '0;
            bcd2_q       <= '0;
            disp1_q      <= '0;
            disp2_q      <= '0;
        end else begin
            vblnk_prev_q <= vga_in.vblnk;
            if (vblank_rise) begin
                score1_q <= score1;
                score2_q <= score2;
                cnt_q    <= '0;
            end else if (in_conv1 || in_conv2) begin
                cnt_q <= cnt_q + 3'd1;
                dd_q  <= dd_next;
                if (cnt_q == 3'd7) begin
                    if (in_conv1) begin
                        bcd1_q <= dd_next[19:8];
                    end else begin
                        bcd2_q <= dd_next[19:8];
                    end
                end
            end
            if (in_commit) begin
                disp1_q <= bcd1_q;
                disp2_q <= bcd2_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline stage 1: region decode
    // ------------------------------------------------------------------
    logic [11:0] rel_x, rel_y;
    logic        in_region;

    logic             in_q1;
    logic [2:0]       char_q1;
    logic [3:0]       row_q1;
    logic [2:0]       col_q1;
    logic [RGB_B-1:0] rgb_q1;
    logic [10:0]      hcount_q1, vcount_q1;
    logic             hblnk_q1, vblnk_q1, hsync_q1, vsync_q1;

    always_comb begin
        rel_x     = {1'b0, vga_in.hcount} - X0_L;
        rel_y     = {1'b0, vga_in.vcount} - Y0_L;
        in_region = ({1'b0, vga_in.hcount} >= X0_L) && (rel_x < 12'd56) &&
                    ({1'b0, vga_in.vcount} >= Y0_L) && (rel_y < 12'd16) &&
                    !vga_in.hblnk && !vga_in.vblnk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q1     <= 1'b0;
            char_q1   <= '0;
            row_q1    <= '0;
            col_q1    <= '0;
            rgb_q1    <= '0;
            hcount_q1 <= '0;
            vcount_q1 <= '0;
            hblnk_q1  <= 1'b0;
            vblnk_q1  <= 1'b0;
            hsync_q1  <= 1'b0;
            vsync_q1  <= 1'b0;
        end else begin
            in_q1     <= in_region;
            char_q1   <= rel_x[5:3];
            row_q1    <= rel_y[3:0];
            col_q1    <= rel_x[2:0];
            rgb_q1    <= rgb_i;
            hcount_q1 <= vga_in.hcount;
            vcount_q1 <= vga_in.vcount;
            hblnk_q1  <= vga_in.hblnk;
            vblnk_q1  <= vga_in.vblnk;
            hsync_q1  <= vga_in.hsync;
            vsync_q1  <= vga_in.vsync;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline stage 2: glyph select, synchronous ROM read, output mux
    // ------------------------------------------------------------------
    logic [3:0]       code;
    logic [RGB_B-1:0] color;
    logic             blank;
    logic [127:0]     glyph_shifted;

    always_comb begin
        code  = 4'd10;
        color = SEP_COLOR;
        case (char_q1)
            3'd0:    begin code = disp1_q[11:8]; color = P1_COLOR; end
            3'd1:    begin code = disp1_q[7:4];  color = P1_COLOR; end
            3'd2:    begin code = disp1_q[3:0];  color = P1_COLOR; end
            3'd4:    begin code = disp2_q[11:8]; color = P2_COLOR; end
            3'd5:    begin code = disp2_q[7:4];  color = P2_COLOR; end
            3'd6:    begin code = disp2_q[3:0];  color = P2_COLOR; end
            default: begin code = 4'd10;         color = SEP_COLOR; end
        endcase
        glyph_shifted = glyph_bits(code) >> {(4'd15 - row_q1), 3'b000};
    end

`ifdef DRAW_SCORE_ZERO_BLANK_EN
    logic lead1_h, lead1_t, lead2_h, lead2_t;

    always_comb begin
        lead1_h = (disp1_q[11:8] == 4'd0);
        lead1_t = lead1_h && (disp1_q[7:4] == 4'd0);
        lead2_h = (disp2_q[11:8] == 4'd0);
        lead2_t = lead2_h && (disp2_q[7:4] == 4'd0);
        blank   = ((char_q1 == 3'd0) && lead1_h) || ((char_q1 == 3'd1) && lead1_t) ||
                  ((char_q1 == 3'd4) && lead2_h) || ((char_q1 == 3'd5) && lead2_t);
    end
`else
    assign blank = 1'b0;
`endif

    logic [7:0]       rom_row_q;
    logic             on_q2;
    logic [2:0]       col_q2;
    logic [RGB_B-1:0] color_q2;
    logic [RGB_B-1:0] rgb_q2;
    logic [10:0]      hcount_q2, vcount_q2;
    logic             hblnk_q2, vblnk_q2, hsync_q2, vsync_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_row_q <= '0;
            on_q2     <= 1'b0;
            col_q2    <= '0;
            color_q2  <= '0;
            rgb_q2    <= '0;
            hcount_q2 <= '0;
            vcount_q2 <= '0;
            hblnk_q2  <= 1'b0;
            vblnk_q2  <= 1'b0;
            hsync_q2  <= 1'b0;
            vsync_q2  <= 1'b0;
        end else begin
            rom_row_q <= glyph_shifted[7:0];
            on_q2     <= in_q1 && !blank;
            col_q2    <= col_q1;
            color_q2  <= color;
            rgb_q2    <= rgb_q1;
            hcount_q2 <= hcount_q1;
            vcount_q2 <= vcount_q1;
            hblnk_q2  <= hblnk_q1;
            vblnk_q2  <= vblnk_q1;
            hsync_q2  <= hsync_q1;
            vsync_q2  <= vsync_q1;
        end
    end

    always_comb begin
        rgb_o = rgb_q2;
        if (on_q2 && rom_row_q[3'd7 - col_q2]) begin
            rgb_o = color_q2;
        end
    end

    assign vga_out.hcount = hcount_q2;
    assign vga_out.vcount = vcount_q2;
    assign vga_out.hblnk  = hblnk_q2;
    assign vga_out.vblnk  = vblnk_q2;
    assign vga_out.hsync  = hsync_q2;
    assign vga_out.vsync  = vsync_q2;

endmodule

// File: tb/tb_draw_score.sv
// Self-checking bench for draw_score: random pixels checked against a
// character-level reference model, plus directed conversion/reset scenarios.
module tb_draw_score;

    localparam int          X0        = 16;
    localparam int          Y0        = 8;
    localparam logic [11:0] P1_COLOR  = 12'h0F0;
    localparam logic [11:0] P2_COLOR  = 12'h00F;
    localparam logic [11:0] SEP_COLOR = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  score1 = '0;
    logic [7:0]  score2 = '0;
    logic [11:0] rgb_i = '0;
    logic [11:0] rgb_o;

    vga_if vin ();
    vga_if vout ();

    draw_score dut (
        .clk     (clk),
        .rst     (rst),
        .score1  (score1),
        .score2  (score2),
        .vga_in  (vin),
        .rgb_i   (rgb_i),
        .vga_out (vout),
        .rgb_o   (rgb_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: scores currently shown on screen.
    int model_s1 = 0;
    int model_s2 = 0;

    // Expectation for the pixel applied one step earlier.
    logic        have_prev = 1'b0;
    logic [11:0] prev_rgb;
    logic [25:0] prev_tim;
    string       prev_tag;

    function automatic logic [127:0] font(input int d);
        case (d)
            0:       return 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            1:       return 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            2:       return 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            3:       return 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            4:       return 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            5:       return 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            6:       return 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            7:       return 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            8:       return 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            9:       return 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            default: return 128'h0000_0018_1818_0000_1818_1800_0000_0000;
        endcase
    endfunction

    function automatic logic [11:0] bcd3(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [11:0] ref_pixel(input int h, input int v, input logic hb,
                                              input logic vb, input logic [11:0] rgb);
        int k, col, row, s, pos, d;
        logic [127:0] g;
        logic [11:0] c;
        bit blank;
        if (hb || vb) return rgb;
        if (h < X0 || h >= X0 + 56 || v < Y0 || v >= Y0 + 16) return rgb;
        k = (h - X0) / 8;
        col = (h - X0) % 8;
        row = v - Y0;
        blank = 0;
        if (k == 3) begin
            d = 10;
            c = SEP_COLOR;
        end else begin
            s = (k < 3) ? model_s1 : model_s2;
            pos = (k < 3) ? k : k - 4;
            c = (k < 3) ? P1_COLOR : P2_COLOR;
            d = (pos == 0) ? s / 100 : (pos == 1) ? (s / 10) % 10 : s % 10;
`ifdef DRAW_SCORE_ZERO_BLANK_EN
            blank = (pos == 0 && s < 100) || (pos == 1 && s < 10);
`endif
        end
        g = font(d);
        if (!blank && g[127 - 8 * row - col]) return c;
        return rgb;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one pixel, advance one clock, check the pixel applied one step
    // earlier (two clock edges of latency in total).
    task automatic apply(input string tag, input int h, input int v, input logic hb,
                         input logic vb, input logic [11:0] rgb);
        logic hs, vs;
        logic [11:0] e;
        hs = 1'($urandom);
        vs = 1'($urandom);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = hs;
        vin.vsync  = vs;
        rgb_i      = rgb;
        e = ref_pixel(h, v, hb, vb, rgb);
        @(posedge clk);
        #1;
        if (have_prev) begin
            chk({prev_tag, "_rgb"}, 32'(rgb_o), 32'(prev_rgb));
            chk({prev_tag, "_timing"},
                32'({vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync}),
                32'(prev_tim));
        end
        have_prev = 1'b1;
        prev_rgb  = e;
        prev_tim  = {11'(h), 11'(v), hb, vb, hs, vs};
        prev_tag  = tag;
    endtask

    task automatic rand_pixels(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            apply(tag, X0 - 8 + int'($urandom_range(0, 72)), Y0 - 4 + int'($urandom_range(0, 24)),
                  ($urandom_range(0, 9) == 0), 1'b0, 12'($urandom));
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rgb"}, 32'(rgb_o), 32'd0);
        chk({tag, "_vga"}, 32'({vout.hcount, vout.vcount, vout.hblnk, vout.vblnk,
                                vout.hsync, vout.vsync}), 32'd0);
        chk({tag, "_idle"}, 32'({dut.in_conv1, dut.in_conv2, dut.in_commit}), 32'd0);
        chk({tag, "_digits1"}, 32'(dut.disp1_q), 32'd0);
        chk({tag, "_digits2"}, 32'(dut.disp2_q), 32'd0);
        chk({tag, "_latched"}, 32'({dut.score1_q, dut.score2_q}), 32'd0);
    endtask

    // Raise vblnk with new scores and verify the commit lands exactly 17 cycles on.
    task automatic commit(input int s1, input int s2);
        score1 = 8'(s1);
        score2 = 8'(s2);
        apply("vb_rise", 100, 600, 1'b0, 1'b1, 12'($urandom));
        for (int i = 1; i < 17; i++) apply("vblank", 100, 600, 1'b0, 1'b1, 12'($urandom));
        chk("pre_commit_digits1", 32'(dut.disp1_q), 32'(bcd3(model_s1)));
        chk("pre_commit_digits2", 32'(dut.disp2_q), 32'(bcd3(model_s2)));
        apply("vblank", 100, 600, 1'b0, 1'b1, 12'($urandom));
        chk("commit_digits1", 32'(dut.disp1_q), 32'(bcd3(s1)));
        chk("commit_digits2", 32'(dut.disp2_q), 32'(bcd3(s2)));
        model_s1 = s1;
        model_s2 = s2;
        apply("vblank_end", 100, 0, 1'b1, 1'b0, 12'($urandom));
    endtask

    initial begin
        // Reset with busy inputs
        vin.hcount = 11'(X0 + 3); vin.vcount = 11'(Y0 + 3);
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.hsync = 1'b1; vin.vsync = 1'b1;
        rgb_i = 12'hABC; score1 = 8'd200; score2 = 8'd100;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        rst = 1'b0;
        have_prev = 1'b1; prev_rgb = '0; prev_tim = '0; prev_tag = "post_reset";

        // Digits start at 000:000
        rand_pixels("zero_frame", 40);

        // 255 / 7 conversion
        commit(255, 7);
        rand_pixels("frame_255_7", 150);

        // Separator dot and region edges
        apply("sep_dot", X0 + 27, Y0 + 8, 1'b0, 1'b0, 12'h123);
        chk("sep_dot_expect", 32'(prev_rgb), 32'(SEP_COLOR));
        apply("right_edge", X0 + 56, Y0 + 8, 1'b0, 1'b0, 12'h456);
        apply("bottom_edge", X0 + 27, Y0 + 16, 1'b0, 1'b0, 12'h789);
        apply("last_col", X0 + 55, Y0 + 8, 1'b0, 1'b0, 12'h321);
        apply("hblank_in_region", X0 + 27, Y0 + 8, 1'b1, 1'b0, 12'h654);

        // Mid-frame score change is not shown until the next commit
        commit(10, 200);
        score1 = 8'd99;
        for (int c = 0; c < 24; c++)
            for (int r = 0; r < 16; r++)
                apply("hold_010", X0 + c, Y0 + r, 1'b0, 1'b0, 12'h0A5);
        commit(99, 200);
        for (int c = 0; c < 24; c++)
            for (int r = 0; r < 16; r++)
                apply("show_099", X0 + c, Y0 + r, 1'b0, 1'b0, 12'h0A5);

        // Two edges 5 cycles apart: only the second set is ever committed
        score1 = 8'd123; score2 = 8'd45;
        apply("rise_a", 100, 600, 1'b0, 1'b1, 12'($urandom));
        apply("blank_a", 100, 600, 1'b0, 1'b1, 12'($urandom));
        apply("blank_a", 100, 600, 1'b0, 1'b1, 12'($urandom));
        apply("gap", 100, 0, 1'b1, 1'b0, 12'($urandom));
        apply("gap", 100, 0, 1'b1, 1'b0, 12'($urandom));
        score1 = 8'd201; score2 = 8'd88;
        apply("rise_b", 100, 600, 1'b0, 1'b1, 12'($urandom));
        for (int i = 1; i < 17; i++) begin
            apply("blank_b", 100, 600, 1'b0, 1'b1, 12'($urandom));
            chk("first_set_never_shown",
                32'((dut.disp1_q == bcd3(123)) || (dut.disp2_q == bcd3(45))), 32'd0);
        end
        chk("restart_not_yet1", 32'(dut.disp1_q), 32'(bcd3(99)));
        chk("restart_not_yet2", 32'(dut.disp2_q), 32'(bcd3(200)));
        apply("blank_b", 100, 600, 1'b0, 1'b1, 12'($urandom));
        chk("restart_commit1", 32'(dut.disp1_q), 32'(bcd3(201)));
        chk("restart_commit2", 32'(dut.disp2_q), 32'(bcd3(88)));
        model_s1 = 201; model_s2 = 88;
        apply("vblank_end", 100, 0, 1'b1, 1'b0, 12'($urandom));
        rand_pixels("frame_201_88", 80);

        // Leading zeros: score1 = 5, score2 = 0
        commit(5, 0);
        apply("lead_char0", X0 + 1, Y0 + 5, 1'b0, 1'b0, 12'h333);
        apply("lead_char1", X0 + 9, Y0 + 5, 1'b0, 1'b0, 12'h333);
        apply("units_char2", X0 + 16, Y0 + 2, 1'b0, 1'b0, 12'h333);
        chk("units_char2_drawn", 32'(prev_rgb), 32'(P1_COLOR));
        apply("lead_char4", X0 + 33, Y0 + 5, 1'b0, 1'b0, 12'h333);
        rand_pixels("frame_5_0", 100);

        // Random scores
        for (int n = 0; n < 3; n++) begin
            commit(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            rand_pixels("frame_rand", 60);
        end

        // Reset during a conversion aborts it
        score1 = 8'd77; score2 = 8'd66;
        apply("rise_rst", 100, 600, 1'b0, 1'b1, 12'($urandom));
        for (int i = 0; i < 5; i++) apply("blank_rst", 100, 600, 1'b0, 1'b1, 12'($urandom));
        #2;
        rst = 1'b1;
        #1;
        reset_checks("mid_reset");
        @(posedge clk);
        #1;
        reset_checks("mid_reset_hold");
        @(negedge clk);
        rst = 1'b0;
        model_s1 = 0; model_s2 = 0;
        have_prev = 1'b1; prev_rgb = '0; prev_tim = '0; prev_tag = "post_reset2";
        rand_pixels("after_abort", 25);
        chk("no_commit_after_abort1", 32'(dut.disp1_q), 32'd0);
        chk("no_commit_after_abort2", 32'(dut.disp2_q), 32'd0);
        chk("idle_after_abort", 32'({dut.in_conv1, dut.in_conv2, dut.in_commit}), 32'd0);

        // Converter still works after reset
        commit(42, 250);
        rand_pixels("frame_42_250", 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
